// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: FSM encoding, widths and the
// buffered instruction entry.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } inst_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer; flush has priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  inst_entry_t      push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output inst_entry_t      head
);

    inst_entry_t      mem_q [DEPTH];
    inst_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push & ~flush;
        do_pop   = pop & ~flush & (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Storage is cleared on reset so the head reads as zero while held in reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues reads to a 1-cycle-latency
// instruction memory, buffers returned words and hands them to decode.
// Handshake: an instruction transfers on a rising edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready, and out_inst /
// out_pc hold steady while out_valid=1 and out_ready=0.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR_W     = 5,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic              fault,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_BOOT  = BOOT;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FAULT = FAULT;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic             pop;
    logic             flush;
    logic             push;
    logic             issue;
    logic [PC_W-1:0]  issue_pc;
    logic             take_redirect;
    logic             redirect_legal;
    logic [CNT_W:0]   slots_used;
    logic [CNT_W-1:0] fifo_count;
    inst_entry_t      fifo_head;

    always_comb begin
        redirect_legal = (redirect_pc[1:0] == 2'b00) &&
                         (redirect_pc[PC_W-1:ADDR_W+2] == '0);
        // reset_n gates the combinational strobes so everything reads zero in reset.
        take_redirect  = reset_n & redirect_valid & (state_q != ST_FAULT);
        out_valid      = (state_q == ST_RUN) && (fifo_count != '0) && !redirect_valid;
        pop            = out_valid & out_ready;
        slots_used     = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        issue         = 1'b0;
        issue_pc      = fetch_pc_q;
        flush         = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (reset_n) begin
                    issue   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = reset_n && (slots_used < (CNT_W + 1)'(FIFO_DEPTH));
            end
            default: begin
                issue = 1'b0;
            end
        endcase

        if (take_redirect) begin
            flush = 1'b1;
            if (redirect_legal) begin
                issue    = 1'b1;
                issue_pc = redirect_pc;
                state_d  = ST_RUN;
            end else begin
                issue    = 1'b0;
                state_d  = ST_FAULT;
            end
        end

        if (issue) begin
            fetch_pc_d    = issue_pc + PC_W'(4);
            inflight_d    = 1'b1;
            inflight_pc_d = issue_pc;
        end

        // Data returning in a flush cycle belongs to the abandoned path.
        push      = inflight_q & ~flush;
        imem_en   = issue;
        imem_addr = issue ? issue_pc[ADDR_W+1:2] : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry ('{pc: inflight_pc_q, inst: imem_rdata}),
        .pop        (pop),
        .flush      (flush),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    assign out_inst  = fifo_head.inst;
    assign out_pc    = fifo_head.pc;
    assign fault     = (state_q == ST_FAULT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 32-word memory model (word k = 0x1000_0000+k).
module tb_fetch_ctrl;

    logic        clock;
    logic        reset_n;
    logic        imem_en;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;
    logic [1:0]  state_dbg;

    logic [31:0] mem [32];
    logic [31:0] exp_pc;
    int          n_vec;
    int          n_err;

    fetch_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault),
        .state_dbg      (state_dbg)
    );

    // Clock and memory model
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + {27'b0, pc[6:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, return at the falling edge to sample.
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clock);
    endtask

    task automatic expect_out(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"}, out_pc, exp_pc);
        check({tag, "_inst"}, out_inst, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_imem_en"}, 32'(imem_en), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_inst"}, out_inst, 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    // Leaves the bench at the falling edge of the BOOT cycle.
    task automatic apply_reset(input logic rv, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clock);
        check_zero_outputs("rst");
        @(posedge clock);
        #1;
        reset_n        = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clock);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        exp_pc         = '0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        imem_rdata     = '0;
        for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + 32'(k);

        // Reset release and sequential stream
        apply_reset(1'b0, 32'd0);
        check("boot_en", 32'(imem_en), 32'd1);
        check("boot_addr", 32'(imem_addr), 32'd0);
        check("boot_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        check("c1_valid", 32'(out_valid), 32'd0);
        check("c1_addr", 32'(imem_addr), 32'd1);
        exp_pc = 32'd0;
        repeat (8) begin
            drive(1'b1, 1'b0, 32'd0);
            expect_out("seq");
        end

        // Backpressure: head holds at 0x20, memory strobe stays low
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pc", out_pc, 32'h20);
            check("bp_inst", out_inst, word_of(32'h20));
            check("bp_en", 32'(imem_en), 32'd0);
        end
        repeat (4) begin
            drive(1'b1, 1'b0, 32'd0);
            expect_out("bp_rel");
        end

        // Redirect with the buffer full (PCs 0x30 and 0x34)
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        check("full_pc", out_pc, 32'h30);
        drive(1'b1, 1'b1, 32'h40);
        check("rd_valid", 32'(out_valid), 32'd0);
        check("rd_en", 32'(imem_en), 32'd1);
        check("rd_addr", 32'(imem_addr), 32'd16);
        drive(1'b1, 1'b0, 32'd0);
        check("rd_c1_valid", 32'(out_valid), 32'd0);
        exp_pc = 32'h40;
        repeat (18) begin
            drive(1'b1, 1'b0, 32'd0);
            expect_out("wrap");
        end
        check("wrap_fault", 32'(fault), 32'd0);

        // Back-to-back redirects: the second wins
        drive(1'b1, 1'b1, 32'h10);
        check("rr1_valid", 32'(out_valid), 32'd0);
        check("rr1_addr", 32'(imem_addr), 32'd4);
        drive(1'b1, 1'b1, 32'h20);
        check("rr2_valid", 32'(out_valid), 32'd0);
        check("rr2_addr", 32'(imem_addr), 32'd8);
        drive(1'b1, 1'b0, 32'd0);
        check("rr_gap_valid", 32'(out_valid), 32'd0);
        exp_pc = 32'h20;
        repeat (3) begin
            drive(1'b1, 1'b0, 32'd0);
            expect_out("rr");
        end

        // Misaligned target traps; FAULT ignores later legal redirects
        drive(1'b1, 1'b1, 32'h42);
        check("mis_en", 32'(imem_en), 32'd0);
        check("mis_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        check("mis_fault", 32'(fault), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 1), 32'h40);
            check("flt_fault", 32'(fault), 32'd1);
            check("flt_en", 32'(imem_en), 32'd0);
            check("flt_valid", 32'(out_valid), 32'd0);
        end

        // Out-of-range target traps
        apply_reset(1'b0, 32'd0);
        check("boot2_en", 32'(imem_en), 32'd1);
        drive(1'b1, 1'b0, 32'd0);
        exp_pc = 32'd0;
        repeat (2) begin
            drive(1'b1, 1'b0, 32'd0);
            expect_out("boot2");
        end
        drive(1'b1, 1'b1, 32'h100);
        check("oor_en", 32'(imem_en), 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        check("oor_fault", 32'(fault), 32'd1);
        check("oor_valid", 32'(out_valid), 32'd0);
        check("oor_state", 32'(state_dbg), 32'd2);

        // Reset in the middle of a redirect with the buffer full
        apply_reset(1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        exp_pc = 32'd0;
        repeat (2) begin
            drive(1'b1, 1'b0, 32'd0);
            expect_out("pre_mid");
        end
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        check("pre_mid_full_pc", out_pc, 32'h8);
        @(posedge clock);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        out_ready      = 1'b1;
        #2;
        reset_n = 1'b0;
        @(negedge clock);
        check_zero_outputs("mid_rst");
        apply_reset(1'b0, 32'd0);
        check("restart_en", 32'(imem_en), 32'd1);
        check("restart_addr", 32'(imem_addr), 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        exp_pc = 32'd0;
        drive(1'b1, 1'b0, 32'd0);
        expect_out("restart");

        // Redirect in the BOOT cycle overrides RESET_PC
        apply_reset(1'b1, 32'h30);
        check("bootrd_en", 32'(imem_en), 32'd1);
        check("bootrd_addr", 32'(imem_addr), 32'd12);
        drive(1'b1, 1'b0, 32'd0);
        check("bootrd_c1_valid", 32'(out_valid), 32'd0);
        exp_pc = 32'h30;
        repeat (2) begin
            drive(1'b1, 1'b0, 32'd0);
            expect_out("bootrd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
